// File: rtl/ckpt_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ckpt_ctrl
//  Purpose  : Checkpoint/restore copy engine on the CPU native memory bus.
//             Passes CPU traffic straight through while idle. On a start
//             pulse it lets any in-flight CPU transfer finish, takes the bus,
//             stalls the CPU and copies a block of 32-bit words
//             RAM->FRAM (checkpoint) or FRAM->RAM (restore), one read and
//             one write per word, then hands the bus back.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    RAM_BASE   byte address of word 0 of the RAM region
//    FRAM_BASE  byte address of word 0 of the FRAM region
//    CNT_BITS   width of the word count and word index
//  Ports
//    clk, reset                 clock, asynchronous active-high reset
//    cpu_mem_*  (valid/instr/addr/wdata/wstrb in, ready/rdata out)
//                               CPU side of the native memory port
//    mem_*      (valid/instr/addr/wdata/wstrb out, ready/rdata in)
//                               fabric side of the native memory port
//    ckpt_start                 pulse: start RAM->FRAM copy
//    rest_start                 pulse: start FRAM->RAM copy
//    xfer_words                 word count, sampled with the start pulse
//    busy                       engine owns or is acquiring the bus
//    done                       one-cycle pulse when the copy completes
// ============================================================================
module ckpt_ctrl #(
    parameter logic [31:0] RAM_BASE  = 32'h2000_0000,
    parameter logic [31:0] FRAM_BASE = 32'h1000_0000,
    parameter int unsigned CNT_BITS  = 16
) (
    input  logic                clk,
    input  logic                reset,

    // CPU side
    input  logic                cpu_mem_valid,
    input  logic                cpu_mem_instr,
    input  logic [31:0]         cpu_mem_addr,
    input  logic [31:0]         cpu_mem_wdata,
    input  logic [3:0]          cpu_mem_wstrb,
    output logic                cpu_mem_ready,
    output logic [31:0]         cpu_mem_rdata,

    // Fabric side
    output logic                mem_valid,
    output logic                mem_instr,
    output logic [31:0]         mem_addr,
    output logic [31:0]         mem_wdata,
    output logic [3:0]          mem_wstrb,
    input  logic                mem_ready,
    input  logic [31:0]         mem_rdata,

    // Engine control
    input  logic                ckpt_start,
    input  logic                rest_start,
    input  logic [CNT_BITS-1:0] xfer_words,
    output logic                busy,
    output logic                done
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DRAIN  = 3'd1,
        S_RD     = 3'd2,
        S_RD_GAP = 3'd3,
        S_WR     = 3'd4,
        S_WR_GAP = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    localparam logic [CNT_BITS-1:0] c_idx_zero = '0;
    localparam logic [CNT_BITS-1:0] c_idx_one  = {{(CNT_BITS-1){1'b0}}, 1'b1};

    state_t                r_state;
    logic                  r_dir_ckpt;   // 1: RAM->FRAM, 0: FRAM->RAM
    logic [CNT_BITS-1:0]   r_len;
    logic [CNT_BITS-1:0]   r_idx;
    logic [31:0]           r_data;
    logic                  r_busy;
    logic                  r_done;

    // Engine-side bus drive, held stable from request until mem_ready.
    logic                  r_eng_valid;
    logic [3:0]            r_eng_wstrb;
    logic [31:0]           r_eng_addr;

    logic [31:0]           w_src_base;
    logic [31:0]           w_dst_base;
    logic [31:0]           w_idx_off;
    logic                  w_pass;
    logic                  w_drain_ok;

    assign w_src_base = r_dir_ckpt ? RAM_BASE  : FRAM_BASE;
    assign w_dst_base = r_dir_ckpt ? FRAM_BASE : RAM_BASE;

    // Word index to byte offset; the address add wraps modulo 2^32.
    assign w_idx_off  = 32'({r_idx, 2'b00});

    // The CPU keeps the bus while idle and while its last transfer drains.
    assign w_pass     = (r_state == S_IDLE) || (r_state == S_DRAIN);

    // Drain finishes when the CPU has nothing outstanding, or when its
    // outstanding transfer completes in this very cycle.
    assign w_drain_ok = !cpu_mem_valid || mem_ready;

    // ------------------------------------------------------------------------
    // Control FSM. Engine bus requests are set up on entry to RD/WR so the
    // address/data/strobes are stable for the whole request.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_dir_ckpt  <= 1'b0;
            r_len       <= c_idx_zero;
            r_idx       <= c_idx_zero;
            r_data      <= 32'h0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_eng_valid <= 1'b0;
            r_eng_wstrb <= 4'h0;
            r_eng_addr  <= 32'h0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (ckpt_start || rest_start) begin
                        // Checkpoint wins when both pulses coincide.
                        r_dir_ckpt <= ckpt_start;
                        r_len      <= xfer_words;
                        r_idx      <= c_idx_zero;
                        r_busy     <= 1'b1;
                        r_state    <= S_DRAIN;
                    end
                end

                S_DRAIN: begin
                    if (w_drain_ok) begin
                        if (r_len != c_idx_zero) begin
                            r_eng_valid <= 1'b1;
                            r_eng_wstrb <= 4'h0;
                            r_eng_addr  <= w_src_base + w_idx_off;
                            r_state     <= S_RD;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end

                S_RD: begin
                    if (mem_ready) begin
                        r_data      <= mem_rdata;
                        r_eng_valid <= 1'b0;
                        r_state     <= S_RD_GAP;
                    end
                end

                S_RD_GAP: begin
                    r_eng_valid <= 1'b1;
                    r_eng_wstrb <= 4'hF;
                    r_eng_addr  <= w_dst_base + w_idx_off;
                    r_state     <= S_WR;
                end

                S_WR: begin
                    if (mem_ready) begin
                        r_idx       <= r_idx + c_idx_one;
                        r_eng_valid <= 1'b0;
                        r_eng_wstrb <= 4'h0;
                        r_state     <= S_WR_GAP;
                    end
                end

                S_WR_GAP: begin
                    // r_idx already counts the word just written.
                    if (r_idx == r_len) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_eng_valid <= 1'b1;
                        r_eng_wstrb <= 4'h0;
                        r_eng_addr  <= w_src_base + w_idx_off;
                        r_state     <= S_RD;
                    end
                end

                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_busy      <= 1'b0;
                    r_eng_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Bus multiplexing. While the engine owns the bus the CPU sees no ready
    // and zero read data, so it simply holds its request.
    // ------------------------------------------------------------------------
    assign mem_valid     = w_pass ? cpu_mem_valid : r_eng_valid;
    assign mem_instr     = w_pass ? cpu_mem_instr : 1'b0;
    assign mem_addr      = w_pass ? cpu_mem_addr  : r_eng_addr;
    assign mem_wdata     = w_pass ? cpu_mem_wdata : r_data;
    assign mem_wstrb     = w_pass ? cpu_mem_wstrb : r_eng_wstrb;
    assign cpu_mem_ready = w_pass ? mem_ready     : 1'b0;
    assign cpu_mem_rdata = w_pass ? mem_rdata     : 32'h0;

    assign busy = r_busy;
    assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_ckpt_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_ckpt_ctrl
//  Purpose  : Self-checking bench for ckpt_ctrl. A word-addressed memory
//             slave with programmable latency sits on the fabric side and
//             logs every completed access. Each copy is predicted from the
//             copy rules (read SRC+4i then write DST+4i, i = 0..N-1) and
//             checked against the log, final memory contents and the
//             done/busy timing derived from slave latency.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ckpt_ctrl;

    localparam logic [31:0] RAM_B  = 32'h2000_0000;
    localparam logic [31:0] FRAM_B = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_mem_valid, cpu_mem_instr;
    logic [31:0] cpu_mem_addr, cpu_mem_wdata;
    logic [3:0]  cpu_mem_wstrb;
    logic        cpu_mem_ready;
    logic [31:0] cpu_mem_rdata;
    logic        mem_valid, mem_instr;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        ckpt_start, rest_start;
    logic [15:0] xfer_words;
    logic        busy, done;

    ckpt_ctrl #(
        .RAM_BASE (RAM_B),
        .FRAM_BASE(FRAM_B),
        .CNT_BITS (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_mem_valid(cpu_mem_valid),
        .cpu_mem_instr(cpu_mem_instr),
        .cpu_mem_addr (cpu_mem_addr),
        .cpu_mem_wdata(cpu_mem_wdata),
        .cpu_mem_wstrb(cpu_mem_wstrb),
        .cpu_mem_ready(cpu_mem_ready),
        .cpu_mem_rdata(cpu_mem_rdata),
        .mem_valid    (mem_valid),
        .mem_instr    (mem_instr),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wstrb    (mem_wstrb),
        .mem_ready    (mem_ready),
        .mem_rdata    (mem_rdata),
        .ckpt_start   (ckpt_start),
        .rest_start   (rest_start),
        .xfer_words   (xfer_words),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Memory slave: responds 'lat' cycles after it first sees valid, holds
    // ready for one cycle. Updates at posedge+3 so it never races the stimulus.
    // ------------------------------------------------------------------------
    logic [31:0] mem [logic [31:0]];
    int          lat = 1;
    int          wcnt = 0;
    logic [31:0] log_addr[$], log_data[$];
    logic        log_wr[$];

    function automatic logic [31:0] rd_mem(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : (a ^ 32'h5A5A_0000);
    endfunction

    initial begin
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #3;
            if (reset) begin
                mem_ready = 1'b0;
                wcnt      = 0;
            end else if (mem_ready) begin
                mem_ready = 1'b0;
                wcnt      = 0;
            end else if (mem_valid) begin
                wcnt++;
                if (wcnt > lat) begin
                    mem_ready = 1'b1;
                    log_addr.push_back(mem_addr);
                    log_wr.push_back(mem_wstrb != 4'h0);
                    if (mem_wstrb != 4'h0) begin
                        mem[mem_addr] = mem_wdata;
                        log_data.push_back(mem_wdata);
                    end else begin
                        mem_rdata = rd_mem(mem_addr);
                        log_data.push_back(mem_rdata);
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Monitor (negedge, all signals settled)
    // ------------------------------------------------------------------------
    int done_cnt, done_cyc, busy_cnt, eng_first_cyc;
    int cpu_rdy_q[$];

    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (busy) busy_cnt++;
        if (cpu_mem_ready) cpu_rdy_q.push_back(cyc);
        if (eng_first_cyc < 0 && busy && mem_valid && mem_wstrb == 4'h0 && mem_addr == RAM_B)
            eng_first_cyc = cyc;
    end

    task automatic clr_mon();
        done_cnt = 0; done_cyc = -1; busy_cnt = 0; eng_first_cyc = -1;
        cpu_rdy_q.delete();
    endtask

    // Expected access list
    logic [31:0] exp_addr[$], exp_data[$];
    logic        exp_wr[$];

    task automatic clr_logs();
        log_addr.delete(); log_data.delete(); log_wr.delete();
        exp_addr.delete(); exp_data.delete(); exp_wr.delete();
    endtask

    task automatic exp_push(input logic [31:0] a, input logic [31:0] d, input logic w);
        exp_addr.push_back(a); exp_data.push_back(d); exp_wr.push_back(w);
    endtask

    task automatic exp_copy(input bit ck, input int n);
        logic [31:0] s, d, v;
        s = ck ? RAM_B : FRAM_B;
        d = ck ? FRAM_B : RAM_B;
        for (int i = 0; i < n; i++) begin
            v = rd_mem(s + 32'(4 * i));
            exp_push(s + 32'(4 * i), v, 1'b0);
            exp_push(d + 32'(4 * i), v, 1'b1);
        end
    endtask

    task automatic check_log(input string tag);
        check_eq({tag, "_nacc"}, 32'(log_addr.size()), 32'(exp_addr.size()));
        for (int i = 0; i < log_addr.size() && i < exp_addr.size(); i++) begin
            check_eq($sformatf("%s_addr%0d", tag, i), log_addr[i], exp_addr[i]);
            check_eq($sformatf("%s_data%0d", tag, i), log_data[i], exp_data[i]);
            check_eq($sformatf("%s_wr%0d", tag, i), 32'(log_wr[i]), 32'(exp_wr[i]));
        end
    endtask

    // ------------------------------------------------------------------------
    // Stimulus helpers (caller is always at posedge+1)
    // ------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pulse(input int mode, input int n, output int s);
        ckpt_start = (mode != 0);
        rest_start = (mode != 1);
        xfer_words = 16'(n);
        s = cyc;
        tick();
        ckpt_start = 1'b0;
        rest_start = 1'b0;
        xfer_words = 16'($urandom);
    endtask

    task automatic cpu_read(input logic [31:0] a, output logic [31:0] d, output bit ok);
        cpu_mem_valid = 1'b1;
        cpu_mem_instr = 1'b0;
        cpu_mem_addr  = a;
        cpu_mem_wstrb = 4'h0;
        ok = 1'b0;
        d  = 32'h0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (cpu_mem_ready) begin
                d  = cpu_mem_rdata;
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        cpu_mem_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // One complete copy: mode 0 restore, 1 checkpoint, 2 both pulses.
    task automatic run_copy(input string tag, input int mode, input int n,
                            input int l, input bit inflight);
        bit          ck, ok, okd;
        int          s, wcost;
        logic [31:0] src, dst, beyond, cpu_a, d, cpu_exp;
        logic [31:0] snap[$];
        ck  = (mode != 0);
        src = ck ? RAM_B : FRAM_B;
        dst = ck ? FRAM_B : RAM_B;
        lat = l;
        for (int i = 0; i < 8; i++) mem[src + 32'(4 * i)] = $urandom;
        for (int i = 0; i < n; i++) snap.push_back(rd_mem(src + 32'(4 * i)));
        beyond  = rd_mem(dst + 32'(4 * n));
        cpu_a   = 32'h40 + 32'(4 * $urandom_range(0, 7));
        cpu_exp = rd_mem(cpu_a);
        clr_logs();
        if (inflight) exp_push(cpu_a, cpu_exp, 1'b0);
        exp_copy(ck, n);
        clr_mon();
        if (inflight) begin
            fork
                cpu_read(cpu_a, d, ok);
                begin
                    tick();
                    start_pulse(mode, n, s);
                end
            join
            check_eq({tag, "_cpu_ok"}, 32'(ok), 32'd1);
            check_eq({tag, "_cpu_rdata"}, d, cpu_exp);
        end else begin
            start_pulse(mode, n, s);
        end
        wait_done(2000, okd);
        check_eq({tag, "_done_seen"}, 32'(okd), 32'd1);
        check_eq({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
        if (!inflight) begin
            wcost = 2 * l + 4;
            check_eq({tag, "_done_cyc"}, 32'(done_cyc), 32'(s + 2 + n * wcost));
            check_eq({tag, "_busy_cyc"}, 32'(busy_cnt), 32'(2 + n * wcost));
        end
        check_eq({tag, "_busy_end"}, 32'(busy), 32'd0);
        check_log(tag);
        for (int i = 0; i < n; i++)
            check_eq($sformatf("%s_dst%0d", tag, i), rd_mem(dst + 32'(4 * i)), snap[i]);
        check_eq({tag, "_beyond"}, rd_mem(dst + 32'(4 * n)), beyond);
    endtask

    // ------------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------------
    initial begin
        logic [31:0] d, d2, pre2, exp10, exp14;
        logic [31:0] snap8[$];
        bit          ok, ok2, okd, found;
        int          s, s2;

        reset = 1'b1;
        cpu_mem_valid = 1'b0; cpu_mem_instr = 1'b0; cpu_mem_addr = 32'h0;
        cpu_mem_wdata = 32'h0; cpu_mem_wstrb = 4'h0;
        ckpt_start = 1'b0; rest_start = 1'b0; xfer_words = 16'h0;
        clr_mon();
        for (int i = 0; i < 16; i++) begin
            mem[RAM_B + 32'(4 * i)]  = $urandom;
            mem[FRAM_B + 32'(4 * i)] = $urandom;
        end
        mem[32'h10] = 32'hC0DE_0010;
        mem[32'h14] = 32'hC0DE_0014;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_mem_valid", 32'(mem_valid), 32'd0);
        reset = 1'b0;
        tick();

        // Passthrough while idle
        cpu_mem_valid = 1'b1; cpu_mem_instr = 1'b1; cpu_mem_addr = 32'h44;
        cpu_mem_wdata = 32'h1234_5678; cpu_mem_wstrb = 4'h3;
        #1;
        check_eq("pass_valid", 32'(mem_valid), 32'd1);
        check_eq("pass_instr", 32'(mem_instr), 32'd1);
        check_eq("pass_addr", mem_addr, 32'h44);
        check_eq("pass_wdata", mem_wdata, 32'h1234_5678);
        check_eq("pass_wstrb", 32'(mem_wstrb), 32'h3);
        cpu_mem_valid = 1'b0; cpu_mem_instr = 1'b0; cpu_mem_wstrb = 4'h0;
        tick();
        cpu_read(32'h10, d, ok);
        check_eq("pass_rd_ok", 32'(ok), 32'd1);
        check_eq("pass_rdata", d, 32'hC0DE_0010);

        // Directed copies
        run_copy("ckpt4", 1, 4, 1, 1'b0);
        run_copy("rest3", 0, 3, 1, 1'b0);
        run_copy("zero", 1, 0, 1, 1'b0);
        run_copy("both", 2, 2, 1, 1'b0);

        // CPU transfer in flight on a 3-cycle slave when the start arrives
        lat = 3;
        clr_logs();
        exp10 = rd_mem(32'h10);
        exp14 = rd_mem(32'h14);
        exp_push(32'h10, exp10, 1'b0);
        exp_copy(1'b1, 2);
        exp_push(32'h14, exp14, 1'b0);
        clr_mon();
        fork
            cpu_read(32'h10, d, ok);
            begin
                tick();
                start_pulse(1, 2, s);
            end
        join
        check_eq("infl_cpu_ok", 32'(ok), 32'd1);
        check_eq("infl_cpu_rdata", d, exp10);
        fork
            cpu_read(32'h14, d2, ok2);
            wait_done(2000, okd);
        join
        check_eq("infl_done_seen", 32'(okd), 32'd1);
        check_eq("infl_done_cnt", 32'(done_cnt), 32'd1);
        check_eq("infl_cpu2_ok", 32'(ok2), 32'd1);
        check_eq("infl_cpu2_rdata", d2, exp14);
        check_eq("infl_nready", 32'(cpu_rdy_q.size()), 32'd2);
        if (cpu_rdy_q.size() >= 2) begin
            check_eq("infl_rd_after_ready", 32'(eng_first_cyc), 32'(cpu_rdy_q[0] + 1));
            check_eq("infl_cpu2_after_done", 32'(cpu_rdy_q[1] > done_cyc), 32'd1);
        end
        check_log("infl");

        // Start pulses while busy are ignored
        lat = 1;
        clr_logs();
        exp_copy(1'b1, 2);
        clr_mon();
        start_pulse(1, 2, s);
        repeat (4) tick();
        start_pulse(2, 7, s2);
        wait_done(2000, okd);
        check_eq("ign_done_seen", 32'(okd), 32'd1);
        check_eq("ign_done_cyc", 32'(done_cyc), 32'(s + 14));
        repeat (20) tick();
        check_eq("ign_done_cnt", 32'(done_cnt), 32'd1);
        check_log("ign");

        // Reset during the write of word 2 of an 8-word checkpoint
        lat = 1;
        for (int i = 0; i < 8; i++) begin
            mem[RAM_B + 32'(4 * i)] = $urandom;
            snap8.push_back(mem[RAM_B + 32'(4 * i)]);
        end
        mem[FRAM_B + 32'h8] = 32'hFEED_0008;
        pre2 = 32'hFEED_0008;
        clr_mon();
        start_pulse(1, 8, s);
        found = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (mem_valid && mem_wstrb == 4'hF && mem_addr == FRAM_B + 32'h8) begin
                found = 1'b1;
                break;
            end
        end
        check_eq("rstmid_wr2_seen", 32'(found), 32'd1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_eq("rstmid_mem_valid", 32'(mem_valid), 32'd0);
        check_eq("rstmid_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) tick();
        check_eq("rstmid_no_done", 32'(done_cnt), 32'd0);
        check_eq("rstmid_fram0", rd_mem(FRAM_B), snap8[0]);
        check_eq("rstmid_fram1", rd_mem(FRAM_B + 32'h4), snap8[1]);
        check_eq("rstmid_fram2", rd_mem(FRAM_B + 32'h8), pre2);
        cpu_read(32'h14, d, ok);
        check_eq("rstmid_pass_ok", 32'(ok), 32'd1);
        check_eq("rstmid_pass_rdata", d, 32'hC0DE_0014);
        run_copy("post_rst", 1, 1, 1, 1'b0);

        // Randomized copies
        for (int it = 0; it < 20; it++) begin
            run_copy($sformatf("rnd%0d", it), int'($urandom_range(0, 2)),
                     int'($urandom_range(0, 6)), int'($urandom_range(1, 3)),
                     1'($urandom_range(0, 1)));
            repeat (int'($urandom_range(0, 3))) tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
